// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the RV32 data-memory arbiter slice.
// Holds the arbiter FSM state type and the timeout-counter sizing helper.
package rv_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Counter only has to reach timeout-1; keep at least one bit so a disabled timeout still elaborates.
  function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: scans from last_grant+1 upward (mod N_CH)
// and returns the first requesting channel as a one-hot vector and an index.
module rr_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned ID_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] last_grant,
  output logic [N_CH-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // NOTE: every output and temporary gets a default before the loop so no path leaves a latch behind.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int unsigned off = 1; off <= N_CH; off++) begin
      sum = {1'b0, last_grant} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(N_CH)) sum = sum - (ID_W+1)'(N_CH);
      idx = sum[ID_W-1:0];
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/rv32_dmem_arbiter.sv
// N-channel round-robin arbiter in front of one shared data memory: one single-beat
// transaction in flight, registered memory fields, per-channel completion and optional timeout.
module rv32_dmem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH-1:0]              req_valid,
  input  logic [N_CH-1:0]              req_write,
  input  logic [N_CH*ADDR_W-1:0]       req_addr,
  input  logic [N_CH*DATA_W-1:0]       req_wdata,
  input  logic [N_CH*(DATA_W/8)-1:0]   req_be,
  output logic [N_CH-1:0]              req_ready,
  output logic [N_CH-1:0]              resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_error,
  output logic                         mem_req,
  output logic                         mem_write,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_be,
  input  logic                         mem_ack,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         busy,
  output logic [$clog2(N_CH)-1:0]      grant_id
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned ID_W     = $clog2(N_CH);
  localparam int unsigned TMO_W    = tmo_cnt_w(TIMEOUT);
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_e          state;
  logic [ID_W-1:0] last_grant;
  logic [TMO_W-1:0] tmo_cnt;

  logic [N_CH-1:0] arb_grant;
  logic [ID_W-1:0] arb_id;
  logic            arb_any;
  logic            timeout_hit;

  rr_arbiter #(.N_CH(N_CH), .ID_W(ID_W)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_id   (arb_id),
    .any        (arb_any)
  );

  assign busy        = (state == ST_BUSY);
  assign mem_req     = busy;
  // Gated by rst directly so no accept can be signalled while reset is held.
  assign req_ready   = (state == ST_IDLE && !rst) ? arb_grant : '0;
  assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_W'(TMO_LAST));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(N_CH - 1);
      grant_id   <= '0;
      tmo_cnt    <= '0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= '0;
      unique case (state)
        ST_IDLE: begin
          if (arb_any) begin
            mem_write  <= req_write[arb_id];
            mem_addr   <= req_addr[arb_id*ADDR_W +: ADDR_W];
            mem_wdata  <= req_wdata[arb_id*DATA_W +: DATA_W];
            mem_be     <= req_be[arb_id*BE_W +: BE_W];
            grant_id   <= arb_id;
            last_grant <= arb_id;
            tmo_cnt    <= '0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // An ack in the final timeout cycle still completes normally.
          if (mem_ack) begin
            resp_valid <= N_CH'(1) << grant_id;
            resp_rdata <= mem_write ? '0 : mem_rdata;
            resp_error <= 1'b0;
            state      <= ST_IDLE;
          end else if (timeout_hit) begin
            resp_valid <= N_CH'(1) << grant_id;
            resp_rdata <= '0;
            resp_error <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_dmem_arbiter.sv
// Scoreboard bench for rv32_dmem_arbiter: a cycle-level reference model queues expected
// completions at accept time; an independent monitor pops and compares on resp_valid.
module tb_rv32_dmem_arbiter;

  localparam int N_CH    = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 8;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [N_CH-1:0]            req_valid = '0;
  logic [N_CH-1:0]            req_write = '0;
  logic [N_CH*ADDR_W-1:0]     req_addr = '0;
  logic [N_CH*DATA_W-1:0]     req_wdata = '0;
  logic [N_CH*BE_W-1:0]       req_be = '0;
  logic [N_CH-1:0]            req_ready;
  logic [N_CH-1:0]            resp_valid;
  logic [DATA_W-1:0]          resp_rdata;
  logic                       resp_error;
  logic                       mem_req;
  logic                       mem_write;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_wdata;
  logic [BE_W-1:0]            mem_be;
  logic                       mem_ack = 1'b0;
  logic [DATA_W-1:0]          mem_rdata = '0;
  logic                       busy;
  logic [ID_W-1:0]            grant_id;

  rv32_dmem_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] rdata;
    logic              err;
    int unsigned       when;
  } exp_t;

  exp_t exp_q[$];
  logic [DATA_W-1:0] hold_rdata = '0;
  logic              hold_err = 1'b0;

  // Per-channel pending request as the cores see it.
  logic              ch_v [N_CH];
  logic              ch_w [N_CH];
  logic [ADDR_W-1:0] ch_a [N_CH];
  logic [DATA_W-1:0] ch_d [N_CH];
  logic [BE_W-1:0]   ch_b [N_CH];
  logic [N_CH-1:0]   consumed = '0;

  // Reference model state.
  logic              m_busy = 1'b0;
  int                m_n = 0;
  int                m_delay = 0;
  int                m_last = N_CH - 1;
  int                m_gid = 0;
  int                cur_ch = 0;
  logic              cur_w;
  logic [ADDR_W-1:0] cur_a;
  logic [DATA_W-1:0] cur_d;
  logic [BE_W-1:0]   cur_b;
  logic [DATA_W-1:0] m_rdata;
  int                g_log[$];
  int unsigned       a_log[$];

  // Stimulus knobs.
  int                gen_pct = 0;
  int                wd_pct = 0;
  int                stray_pct = 0;
  int                force_delay = -1;
  logic              force_rdata_en = 1'b0;
  logic [DATA_W-1:0] force_rdata = '0;

  function automatic logic [N_CH-1:0] oh(input int i);
    logic [N_CH-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [N_CH-1:0] pending();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = ch_v[i];
    return v;
  endfunction

  // Round-robin rule: first pending channel after the last grant, wrapping.
  function automatic int rr_pick(input logic [N_CH-1:0] v, input int last);
    for (int k = 1; k <= N_CH; k++) begin
      if (v[(last + k) % N_CH]) return (last + k) % N_CH;
    end
    return -1;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < N_CH; i++) begin
      req_valid[i]                  = ch_v[i];
      req_write[i]                  = ch_w[i];
      req_addr[i*ADDR_W +: ADDR_W]  = ch_a[i];
      req_wdata[i*DATA_W +: DATA_W] = ch_d[i];
      req_be[i*BE_W +: BE_W]        = ch_b[i];
    end
  endtask

  task automatic post(input int i, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
    ch_v[i] = 1'b1;
    ch_w[i] = w;
    ch_a[i] = a;
    ch_d[i] = d;
    ch_b[i] = b;
  endtask

  task automatic accept(input int g);
    logic err;
    int   d_eff;
    consumed[g] = 1'b1;
    cur_ch = g; cur_w = ch_w[g]; cur_a = ch_a[g]; cur_d = ch_d[g]; cur_b = ch_b[g];
    m_last = g;
    m_gid  = g;
    g_log.push_back(g);
    a_log.push_back(cyc);
    m_busy  = 1'b1;
    m_n     = 0;
    m_delay = (force_delay >= 0) ? force_delay : $urandom_range(0, 10);
    m_rdata = force_rdata_en ? force_rdata : DATA_W'($urandom);
    err     = (m_delay >= TIMEOUT);
    d_eff   = err ? TIMEOUT - 1 : m_delay;
    exp_q.push_back('{ch: g, rdata: (err || cur_w) ? '0 : m_rdata, err: err,
                      when: cyc + 2 + d_eff});
  endtask

  // One clock cycle: drive inputs just after the edge, check and advance the model mid-cycle.
  task automatic step();
    int g;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_CH; i++) if (consumed[i]) ch_v[i] = 1'b0;
    consumed = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!ch_v[i] && $urandom_range(0, 99) < gen_pct)
        post(i, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), BE_W'($urandom));
      else if (ch_v[i] && $urandom_range(0, 99) < wd_pct)
        ch_v[i] = 1'b0;
    end
    if (m_busy) begin
      mem_ack   = (m_n == m_delay);
      mem_rdata = mem_ack ? m_rdata : DATA_W'($urandom);
    end else begin
      mem_ack   = ($urandom_range(0, 99) < stray_pct);
      mem_rdata = DATA_W'($urandom);
    end
    drive_bus();
    @(negedge clk);
    if (m_busy) begin
      check("mem_req_busy", 64'(mem_req), 64'(1));
      check("busy_busy", 64'(busy), 64'(1));
      check("req_ready_busy", 64'(req_ready), 64'(0));
      check("mem_write", 64'(mem_write), 64'(cur_w));
      check("mem_addr", 64'(mem_addr), 64'(cur_a));
      check("mem_wdata", 64'(mem_wdata), 64'(cur_d));
      check("mem_be", 64'(mem_be), 64'(cur_b));
      check("grant_id_busy", 64'(grant_id), 64'(cur_ch));
      if (mem_ack || m_n == TIMEOUT - 1) m_busy = 1'b0;
      else m_n++;
    end else begin
      check("mem_req_idle", 64'(mem_req), 64'(0));
      check("busy_idle", 64'(busy), 64'(0));
      check("grant_id_idle", 64'(grant_id), 64'(m_gid));
      g = rr_pick(pending(), m_last);
      if (g < 0) check("req_ready_idle", 64'(req_ready), 64'(0));
      else begin
        check("req_ready_grant", 64'(req_ready), 64'(oh(g)));
        accept(g);
      end
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mem_req_async", 64'(mem_req), 64'(0));
    check("rst_busy_async", 64'(busy), 64'(0));
    check("rst_req_ready_async", 64'(req_ready), 64'(0));
    exp_q.delete();
    hold_rdata = '0;
    hold_err   = 1'b0;
    m_busy = 1'b0;
    m_last = N_CH - 1;
    m_gid  = 0;
    consumed = '0;
    for (int i = 0; i < N_CH; i++) ch_v[i] = 1'b0;
    mem_ack = 1'b0;
    drive_bus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant_id", 64'(grant_id), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic settle();
    gen_pct = 0;
    wd_pct = 0;
    for (int i = 0; i < 200 && (m_busy || exp_q.size() != 0 || pending() != '0); i++) step();
    step();
  endtask

  // Monitor: independent of stimulus, compares each completion with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
      end else if (resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'(resp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("resp_valid", 64'(resp_valid), 64'(oh(e.ch)));
          check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
          check("resp_error", 64'(resp_error), 64'(e.err));
          check("resp_cycle", 64'(cyc), 64'(e.when));
          hold_rdata = e.rdata;
          hold_err   = e.err;
        end
      end else begin
        check("resp_rdata_hold", 64'(resp_rdata), 64'(hold_rdata));
        check("resp_error_hold", 64'(resp_error), 64'(hold_err));
      end
    end
  end

  initial begin
    int exp_seq[5] = '{0, 1, 2, 3, 0};

    // Reset with every channel requesting: nothing may be accepted.
    for (int i = 0; i < N_CH; i++)
      post(i, 1'b1, ADDR_W'($urandom), DATA_W'($urandom), BE_W'($urandom));
    drive_bus();
    @(negedge clk);
    check("rst_req_ready_held", 64'(req_ready), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_mem_be", 64'(mem_be), 64'(0));
    check("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    check("rst_resp_error", 64'(resp_error), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant_id0", 64'(grant_id), 64'(0));
    for (int i = 0; i < N_CH; i++) ch_v[i] = 1'b0;
    drive_bus();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single load on channel 2, ack 3 cycles after mem_req rises.
    force_delay = 3;
    force_rdata_en = 1'b1;
    force_rdata = 32'hDEADBEEF;
    post(2, 1'b0, 32'h100, 32'h0, 4'hF);
    repeat (8) step();
    force_rdata_en = 1'b0;

    // Stray acks while idle must change nothing.
    stray_pct = 60;
    repeat (6) step();
    stray_pct = 0;

    // Store on channel 1.
    force_delay = 2;
    post(1, 1'b1, 32'h40, 32'h11223344, 4'b0011);
    repeat (6) step();

    // Timeout with no ack, then ack in the last allowed cycle.
    force_delay = 100;
    post(0, 1'b0, 32'h200, 32'h0, 4'hF);
    repeat (12) step();
    force_delay = TIMEOUT - 1;
    post(0, 1'b0, 32'h204, 32'h0, 4'hF);
    repeat (12) step();

    // Reset mid-BUSY on channel 1; afterwards channel 0 wins over channel 2.
    force_delay = 100;
    post(1, 1'b0, 32'h300, 32'h0, 4'hF);
    repeat (4) step();
    check("midrst_was_busy", 64'(mem_req), 64'(1));
    do_reset();
    force_delay = 1;
    post(0, 1'b0, 32'h400, 32'h0, 4'hF);
    post(2, 1'b0, 32'h500, 32'h0, 4'hF);
    g_log.delete();
    repeat (8) step();
    check("grant_after_reset", 64'(g_log.size() > 0 ? g_log[0] : -1), 64'(0));

    // All channels continuously valid with zero-latency ack from reset state.
    settle();
    do_reset();
    force_delay = 0;
    gen_pct = 100;
    g_log.delete();
    a_log.delete();
    repeat (12) step();
    for (int i = 0; i < 5; i++)
      check("rr_seq", 64'(g_log.size() > i ? g_log[i] : -1), 64'(exp_seq[i]));
    for (int i = 0; i < 4; i++)
      check("rr_spacing", 64'(a_log.size() > i + 1 ? a_log[i+1] - a_log[i] : 0), 64'(2));

    // Randomised traffic with stalls, timeouts, withdrawals and stray acks.
    force_delay = -1;
    gen_pct = 30;
    wd_pct = 5;
    stray_pct = 20;
    repeat (3000) step();
    stray_pct = 0;
    settle();
    check("drain_queue", 64'(exp_q.size()), 64'(0));
    check("drain_idle", 64'(m_busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_dmem_arbiter.md
# rv32_dmem_arbiter

Parametrised N-channel data-memory arbiter placed between the data ports of N_CH RV32I Harvard cores and one shared data memory. Each core issues single-beat loads/stores (address, write data, byte enables); the block grants channels round-robin, forwards one transaction at a time to memory over a req/ack handshake, and returns a per-channel completion with read data. Memory stalls are tolerated, and an optional timeout converts a hung access into an error completion.

## Interface
- N_CH, 4, number of core channels (≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); BE_W = DATA_W/8
- TIMEOUT, 256, cycles in BUSY without mem_ack before error completion; 0 disables
- clock  in  1  single clock, rising edge
- async_reset  in  1  asynchronous, active-high reset
- req_valid  in  N_CH  per-channel request pending; held until req_ready
- req_write  in  N_CH  1 = store, 0 = load
- req_addr  in  N_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_CH*DATA_W  store data, same packing
- req_be  in  N_CH*BE_W  byte enables, same packing
- req_ready  out  N_CH  one-hot accept pulse
- resp_valid  out  N_CH  one-hot completion pulse
- resp_rdata  out  DATA_W  read data, shared across channels
- resp_error  out  1  completion was a timeout
- mem_req  out  1  memory access in progress
- mem_write, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/BE_W  registered transaction fields
- mem_ack  in  1  one-cycle memory completion
- mem_rdata  in  DATA_W  valid in mem_ack cycle
- busy  out  1  state is BUSY
- grant_id  out  $clog2(N_CH)  channel owning current/last transaction

## Operation
- States: IDLE, BUSY.
- IDLE: if any req_valid, pick first set channel scanning from last_grant+1 modulo N_CH; req_ready[g]=1 combinationally that cycle; at edge latch fields into mem_*, grant_id←g, last_grant←g, go BUSY. No valid: stay IDLE, req_ready=0.
- BUSY: mem_req=1, mem_* stable, req_ready=0. Timeout counter counts up from 0.
- mem_ack in BUSY: at edge resp_valid[grant_id]=1 for one cycle, resp_rdata←mem_rdata for loads, 0 for stores; resp_error=0; go IDLE.
- TIMEOUT≠0 and counter reaches TIMEOUT−1 without ack: at edge mem_req drops, resp_valid[grant_id]=1, resp_rdata=0, resp_error=1, go IDLE. mem_ack on that same cycle wins (normal completion).
- mem_ack in IDLE: ignored.
- resp_rdata/resp_error hold until next completion.
- Requests withdrawn before req_ready are permitted; no transaction issued.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_rdata 0, resp_error 0, mem_req 0, mem_write 0, mem_addr 0, mem_wdata 0, mem_be 0, busy 0, grant_id 0, last_grant N_CH−1 (channel 0 first), counter 0. req_ready forced 0 while async_reset high.
- Accept cycle T: req_ready high; mem_req high from T+1.
- mem_ack in cycle T+k (k≥1) → resp_valid in T+k+1, also an IDLE cycle: a new request may be accepted in that cycle. Minimum turnaround 2 cycles/transaction.
- Reset mid-BUSY: mem_req drops immediately (asynchronous), no completion pulse, pending transaction lost.
- Round-robin fairness: with all channels continuously valid, grants rotate 0,1,…,N_CH−1,0.

## Structure
- Package rv_mem_pkg: state enum (IDLE, BUSY), default ADDR_W/DATA_W constants, timeout counter width function.
- Sub-module rr_arbiter: combinational rotate-priority one-hot grant from req vector and last_grant; parametrised by N_CH.
- Top holds FSM, field registers, timeout counter, response registers.

## Test plan
- Single load ch2, addr 0x100, mem_ack 3 cycles after mem_req with rdata 0xDEADBEEF → resp_valid=0b0100 one cycle, resp_rdata 0xDEADBEEF, resp_error 0.
- All 4 channels valid continuously, ack same cycle as mem_req → grants 0,1,2,3,0, each completion 2 cycles apart.
- Store ch1 addr 0x40 data 0x11223344 be 0b0011 → mem_write=1, mem_be 0011, fields stable whole BUSY, resp_rdata 0.
- TIMEOUT=8, never ack → mem_req high 8 cycles, then resp_valid ch0, resp_error 1, resp_rdata 0; ack on 8th cycle instead gives normal completion.
- async_reset pulse mid-BUSY → mem_req 0 immediately, no resp_valid, next grant goes to channel 0.
- Stray mem_ack in IDLE → no outputs change.
